// File: rtl/mult_div_unit_pkg.sv
// Shared CPU definitions for the HI/LO multiply-divide unit:
// op codes, latency constants and small decode helpers.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101,
        MD_MFLO  = 3'b110,
        MD_MFHI  = 3'b111
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;
    localparam int unsigned CNT_W       = 4;

    // Only the four arithmetic ops (top op bit clear) are launched by start.
    function automatic logic md_is_launch(input md_op_e op);
        return ~op[2];
    endfunction

    function automatic logic [CNT_W-1:0] md_latency(input md_op_e op);
        return op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    endfunction

endpackage

// File: rtl/mult_div_unit_md_compute.sv
// Combinational datapath: 64-bit {hi,lo} result for mult/multu/div/divu,
// plus a divide-by-zero flag.
module md_compute
    import mult_div_unit_pkg::*;
(
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  md_op_e      op_i,
    output logic [63:0] result_o,
    output logic        div_by_zero_o
);

    logic               rt_zero;
    logic               div_ovf;
    logic        [31:0] divisor_s;
    logic        [31:0] divisor_u;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    assign rt_zero = (rt_i == 32'd0);
    // INT_MIN / -1 overflows; dividing by 1 instead yields the required 0x80000000 rem 0.
    assign div_ovf = (rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF);

    assign divisor_s = (rt_zero || div_ovf) ? 32'd1 : rt_i;
    assign divisor_u = rt_zero ? 32'd1 : rt_i;

    assign quo_s = $signed(rs_i) / $signed(divisor_s);
    assign rem_s = $signed(rs_i) % $signed(divisor_s);
    assign quo_u = rs_i / divisor_u;
    assign rem_u = rs_i % divisor_u;

    assign prod_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
    assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};

    always_comb begin
        result_o      = '0;
        div_by_zero_o = 1'b0;
        case (op_i)
            MD_MULT:  result_o = prod_s;
            MD_MULTU: result_o = prod_u;
            MD_DIV: begin
                result_o      = {rem_s, quo_s};
                div_by_zero_o = rt_zero;
            end
            MD_DIVU: begin
                result_o      = {rem_u, quo_u};
                div_by_zero_o = rt_zero;
            end
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply-divide unit: IDLE/RUN FSM with a latency
// down-counter, pending result registers and the architectural HI/LO pair.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [2:0]  Multiop,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] low
);

    md_op_e           op;
    logic [63:0]      result;
    logic             div_by_zero;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      pend_q, pend_d;
    logic             pend_dz_q, pend_dz_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    assign op = md_op_e'(Multiop);

    md_compute u_md_compute (
        .rs_i          (rs),
        .rt_i          (rt),
        .op_i          (op),
        .result_o      (result),
        .div_by_zero_o (div_by_zero)
    );

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_dz_d = pend_dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start && md_is_launch(op)) begin
                    state_d   = ST_RUN;
                    cnt_d     = md_latency(op);
                    pend_d    = result;
                    pend_dz_d = div_by_zero;
                end
                if (op == MD_MTHI) hi_d = rs;
                if (op == MD_MTLO) lo_d = rs;
            end
            ST_RUN: begin
                // start, mthi and mtlo are all ignored while an op is in flight.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (!pend_dz_q) {hi_d, lo_d} = pend_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments only.
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_dz_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_dz_q <= pend_dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign hi   = hi_q;
    assign low  = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed results.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [2:0]  Multiop;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] low;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .rs      (rs),
        .rt      (rt),
        .Multiop (Multiop),
        .start   (start),
        .busy    (busy),
        .hi      (hi),
        .low     (low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_hi"}, 64'(hi), 64'(m_hi));
        check({tag, "_lo"}, 64'(low), 64'(m_lo));
    endtask

    // Launch an op, check busy over T..T+N+1, scrambling operands during RUN.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        Multiop = op; rs = a; rt = b; start = 1'b1;
        check({tag, "_busyT"}, 64'(busy), 64'd0);
        tick();
        start = 1'b0; Multiop = MD_MFLO; rs = 32'hDEAD_BEEF; rt = 32'h0000_0001;
        for (int i = 1; i <= n; i++) begin
            check($sformatf("%s_busy%0d", tag, i), 64'(busy), 64'd1);
            if (i == n) check_regs({tag, "_pre"});
            tick();
        end
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        m_hi = exp_hi; m_lo = exp_lo;
        check_regs(tag);
    endtask

    task automatic move(input string tag, input logic [2:0] op, input logic [31:0] val);
        Multiop = op; rs = val;
        tick();
        Multiop = MD_MFLO;
        if (op == MD_MTHI) m_hi = val; else m_lo = val;
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check_regs(tag);
    endtask

    initial begin
        reset = 1'b1; rs = '0; rt = '0; Multiop = MD_MFLO; start = 1'b0;
        m_hi = '0; m_lo = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check_regs("rst");

        run_op("mult",   MD_MULT,  32'hFFFF_FFFE, 32'd3,        MULT_CYCLES, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu",  MD_MULTU, 32'hFFFF_FFFF, 32'd2,        MULT_CYCLES, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div",    MD_DIV,   32'hFFFF_FFF9, 32'd2,        DIV_CYCLES,  32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divovf", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DIV_CYCLES, 32'h0000_0000, 32'h8000_0000);
        run_op("divu",   MD_DIVU,  32'd100,       32'd7,        DIV_CYCLES,  32'h0000_0002, 32'h0000_000E);

        move("mthi", MD_MTHI, 32'h11);
        move("mtlo", MD_MTLO, 32'h22);
        run_op("divu0", MD_DIVU, 32'h1234, 32'd0, DIV_CYCLES, 32'h11, 32'h22);

        // start with a non-arithmetic op must not launch anything
        Multiop = MD_MFHI; start = 1'b1;
        tick();
        start = 1'b0; Multiop = MD_MFLO;
        check("mfhi_start_busy", 64'(busy), 64'd0);
        check_regs("mfhi_start");

        // div start and mthi during a running mult are ignored
        Multiop = MD_MULT; rs = 32'h10; rt = 32'h20; start = 1'b1;
        check("ign_busyT", 64'(busy), 64'd0);
        tick();
        start = 1'b0; Multiop = MD_MFLO;
        check("ign_busy1", 64'(busy), 64'd1);
        tick();
        Multiop = MD_DIV; rs = 32'd100; rt = 32'd3; start = 1'b1;
        check("ign_busy2", 64'(busy), 64'd1);
        tick();
        start = 1'b0; Multiop = MD_MTHI; rs = 32'h55;
        check("ign_busy3", 64'(busy), 64'd1);
        tick();
        Multiop = MD_MFLO;
        check("ign_busy4", 64'(busy), 64'd1);
        tick();
        check("ign_busy5", 64'(busy), 64'd1);
        check_regs("ign_pre");
        tick();
        m_hi = 32'h0; m_lo = 32'h200;
        check("ign_done", 64'(busy), 64'd0);
        check_regs("ign");
        tick();
        check("ign_norelaunch", 64'(busy), 64'd0);
        check_regs("ign_after");

        // reset on busy cycle 4 of a div aborts it
        Multiop = MD_DIV; rs = 32'd100; rt = 32'd7; start = 1'b1;
        tick();
        start = 1'b0; Multiop = MD_MFLO;
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("abort_busy%0d", i), 64'(busy), 64'd1);
            tick();
        end
        check("abort_busy4", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("abort_busy", 64'(busy), 64'd0);
        check_regs("abort");
        for (int i = 0; i < 12; i++) tick();
        check("abort_late_busy", 64'(busy), 64'd0);
        check_regs("abort_late");
        move("mtlo_abcd", MD_MTLO, 32'hABCD);

        // reset wins over a simultaneous mthi
        move("mthi99", MD_MTHI, 32'h99);
        Multiop = MD_MTHI; rs = 32'h77; reset = 1'b1;
        tick();
        reset = 1'b0; Multiop = MD_MFLO;
        m_hi = '0; m_lo = '0;
        check_regs("rst_prio");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as the codebase does: clk and reset.
REQ-002 Port clk SHALL be: clk  input  1  rising-edge clock.
REQ-003 Port reset SHALL be: reset  input  1  synchronous active-high reset.
REQ-004 Port rs SHALL be: rs  input  32  forwarded EX-stage rs operand.
REQ-005 Port rt SHALL be: rt  input  32  forwarded EX-stage rt operand.
REQ-006 Port Multiop SHALL be: Multiop  input  3  op code (see REQ-009).
REQ-007 Port start SHALL be: start  input  1  one-cycle launch strobe for mult/div ops.
REQ-008 Outputs SHALL be: busy (output, 1, operation in flight), hi (output, 32, HI register) and low (output, 32, LO register).
REQ-009 Multiop encoding SHALL be: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 mflo, 111 mfhi.

Function
REQ-010 State machine SHALL be IDLE / RUN.
- IDLE: busy=0.
- RUN: busy=1, with a down-counter running.
REQ-011 In IDLE, start=1 with Multiop in 000..011 SHALL latch the computed result into pending registers and enter RUN on the next edge.
- Counter SHALL load 5 for mult/multu.
- Counter SHALL load 10 for div/divu.
REQ-012 Busy SHALL be 1 for exactly N cycles, T+1..T+N, where T is the start cycle; it SHALL be 0 in cycle T.
REQ-013 On the edge ending cycle T+N, hi/low SHALL be written from the pending registers and the FSM SHALL return to IDLE.
- The new values SHALL be visible from T+N+1, when busy=0.
REQ-014 mult SHALL produce the signed 64-bit product of rs*rt; multu SHALL produce the unsigned product; {hi,low} SHALL equal the product.
REQ-015 div SHALL be signed: quotient truncated toward zero into low, remainder into hi with the sign of the dividend.
REQ-016 divu SHALL be unsigned: quotient into low, remainder into hi.
REQ-017 Signed 0x80000000 / 0xFFFFFFFF SHALL give low=0x80000000, hi=0.
REQ-018 Divide by zero (rt=0) SHALL still run the full 10-cycle busy period and leave hi and low unchanged.
REQ-019 mthi and mtlo SHALL not use start.
- When Multiop=100 (mthi) and busy=0, hi SHALL be written with rs at the edge.
- When Multiop=101 (mtlo) and busy=0, low SHALL be written with rs at the edge.
- Latency SHALL be 1 edge and busy SHALL stay 0.
REQ-020 mflo and mfhi SHALL not change any state; the hi/low outputs SHALL be combinational register reads.
REQ-021 start asserted while busy=1 SHALL be ignored: no relaunch, counter unaffected.
REQ-022 mthi or mtlo presented while busy=1 SHALL be ignored, because the hazard unit stalls these ops.
REQ-023 start with Multiop in 100..111 SHALL be ignored.
REQ-024 hi and low SHALL hold their values at all times other than a completion edge, an mthi/mtlo write, or reset.
REQ-025 Operands SHALL be sampled only in the start cycle; rs/rt changes during RUN SHALL have no effect.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE, busy=0, hi=0, low=0, counter=0, and pending registers=0.
REQ-027 Reset during RUN SHALL abort the operation, and hi/low SHALL not receive the pending result.
REQ-028 reset SHALL take priority over start, mthi and mtlo in the same cycle.

Structure
REQ-029 Op-code constants (REQ-009) and latency constants (MULT_CYCLES=5, DIV_CYCLES=10) SHALL live in the shared CPU definitions package.
REQ-030 One combinational sub-module, md_compute, SHALL produce the 64-bit {hi,lo} result from rs, rt and the op.
- It SHALL flag divide-by-zero.
- The FSM, counter and HI/LO registers SHALL remain in mult_div_unit.

Verification
REQ-031 Stimulus: mult with rs=0xFFFFFFFE (-2), rt=3, start=1 for one cycle. Required: busy=1 for cycles 1..5 after start; then hi=0xFFFFFFFF, low=0xFFFFFFFA.
REQ-032 Stimulus: multu with rs=0xFFFFFFFF, rt=2. Required: busy=1 for 5 cycles; then hi=0x00000001, low=0xFFFFFFFE.
REQ-033 Stimulus: div with rs=-7 (0xFFFFFFF9), rt=2. Required: busy=1 for 10 cycles; then low=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-034 Stimulus: divu with rt=0 while hi=0x11, low=0x22. Required: busy=1 for 10 cycles; hi=0x11 and low=0x22 unchanged.
REQ-035 Stimulus: start a mult, then assert start with a div on cycle 2 and mthi with rs=0x55 on cycle 3. Required: both ignored; the mult result appears after 5 busy cycles.
REQ-036 Stimulus: start a div, then assert reset on busy cycle 4. Required: next cycle busy=0, hi=0, low=0; afterwards mtlo with rs=0xABCD gives low=0xABCD one edge later.
